// File: rtl/data_memory_if.sv
// -----------------------------------------------------------------------------
// data_memory_if
//   Bus between the memory controller / debug unit (master) and the data
//   memory (slave).
//
//   Pipeline side:
//     i_mem_read, i_mem_write           load / store strobes
//     i_word_en, i_halfword_en, i_byte_en access size (exactly one set)
//     i_address   [NB_ADDR-1:0]         byte address; [1:0] lane offset
//     i_write_data[NB_DATA-1:0]         store data, right-aligned
//     o_read_data [NB_DATA-1:0]         load data, right-aligned, zero-filled
//     o_misaligned                      one-cycle flag for an illegal access
//   Debug side:
//     i_debug_req, i_debug_addr         word read request and word index
//     o_debug_data, o_debug_valid       response word and one-cycle strobe
//     o_debug_state                     debug arbiter FSM state (observability)
//
//   Debug handshake: i_debug_req is sampled only while the arbiter is idle.
//   Once accepted, exactly one o_debug_valid pulse follows, with the word in
//   o_debug_data in that same cycle. Requests raised while a request is
//   outstanding are dropped, so the master should wait for o_debug_valid
//   before issuing the next one.
// -----------------------------------------------------------------------------
interface data_memory_if #(
  parameter int NB_DATA = 32,
  parameter int N_WORDS = 32,
  parameter int NB_ADDR = 7
);
  localparam int NB_IDX = $clog2(N_WORDS);

  logic               i_mem_read;
  logic               i_mem_write;
  logic               i_word_en;
  logic               i_halfword_en;
  logic               i_byte_en;
  logic [NB_ADDR-1:0] i_address;
  logic [NB_DATA-1:0] i_write_data;
  logic [NB_DATA-1:0] o_read_data;
  logic               o_misaligned;

  logic               i_debug_req;
  logic [NB_IDX-1:0]  i_debug_addr;
  logic [NB_DATA-1:0] o_debug_data;
  logic               o_debug_valid;
  logic [1:0]         o_debug_state;

  modport master (
    output i_mem_read, i_mem_write, i_word_en, i_halfword_en, i_byte_en,
    output i_address, i_write_data, i_debug_req, i_debug_addr,
    input  o_read_data, o_misaligned, o_debug_data, o_debug_valid,
    input  o_debug_state
  );

  modport slave (
    input  i_mem_read, i_mem_write, i_word_en, i_halfword_en, i_byte_en,
    input  i_address, i_write_data, i_debug_req, i_debug_addr,
    output o_read_data, o_misaligned, o_debug_data, o_debug_valid,
    output o_debug_state
  );
endinterface

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Byte-addressable, little-endian data memory for the pipeline with a
//   low-priority debug word-read port.
//
//   Ports:
//     i_clock  single clock, all state updates on the rising edge
//     i_reset  synchronous active-high reset; clears memory and all outputs
//     bus      data_memory_if.slave (pipeline load/store + debug read)
//
//   Pipeline accesses: byte at any offset, halfword at offset 0/2, word at
//   offset 0. Legal loads return the addressed lane(s) shifted to bit 0 one
//   cycle later; illegal accesses write nothing, return 0 and raise
//   o_misaligned for one cycle. Read and write in the same cycle returns the
//   pre-write contents.
//
//   Debug reads are served only in cycles without a pipeline access, so the
//   pipeline is never stalled by the debug unit.
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int N_WORDS = 32,
  parameter int NB_ADDR = 7
) (
  input  logic          i_clock,
  input  logic          i_reset,
  data_memory_if.slave  bus
);

  localparam int NB_IDX   = $clog2(N_WORDS);
  localparam int NB_LANES = NB_DATA / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RESPOND = 2'd2
  } dbg_state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0] mem [N_WORDS];

  // ---------------------------------------------------------------------------
  // Pipeline access decode
  // ---------------------------------------------------------------------------
  logic [1:0]          offset;
  logic [NB_IDX-1:0]   word_idx;
  logic                access;
  logic                size_onehot;
  logic                aligned;
  logic                legal;
  logic [NB_LANES-1:0] lane_mask;
  logic [NB_DATA-1:0]  bit_mask;
  logic [NB_DATA-1:0]  size_mask;
  logic [NB_DATA-1:0]  wdata_shift;
  logic [NB_DATA-1:0]  cur_word;
  logic [NB_DATA-1:0]  rdata_aligned;
  logic [NB_DATA-1:0]  merged_word;

  assign offset   = bus.i_address[1:0];
  assign word_idx = bus.i_address[NB_ADDR-1:2];
  assign access   = bus.i_mem_read | bus.i_mem_write;
  assign cur_word = mem[word_idx];

  always_comb begin
    size_onehot = ( bus.i_word_en & ~bus.i_halfword_en & ~bus.i_byte_en) |
                  (~bus.i_word_en &  bus.i_halfword_en & ~bus.i_byte_en) |
                  (~bus.i_word_en & ~bus.i_halfword_en &  bus.i_byte_en);

    aligned   = 1'b0;
    lane_mask = '0;
    size_mask = '0;
    if (bus.i_byte_en) begin
      aligned   = 1'b1;
      lane_mask = NB_LANES'(1) << offset;
      size_mask = NB_DATA'(8'hFF);
    end else if (bus.i_halfword_en) begin
      aligned   = ~offset[0];
      lane_mask = NB_LANES'(2'b11) << offset;
      size_mask = NB_DATA'(16'hFFFF);
    end else if (bus.i_word_en) begin
      aligned   = (offset == 2'b00);
      lane_mask = '1;
      size_mask = '1;
    end

    legal = size_onehot & aligned;
  end

  // Expand the lane enables into a per-bit write mask.
  always_comb begin
    bit_mask = '0;
    for (int k = 0; k < NB_LANES; k++) begin
      bit_mask[8*k +: 8] = {8{lane_mask[k]}};
    end
  end

  // Store data arrives right-aligned; move it up to its lane offset. Bits that
  // land outside the addressed lanes are removed by bit_mask.
  assign wdata_shift   = bus.i_write_data << {offset, 3'b000};
  assign merged_word   = (cur_word & ~bit_mask) | (wdata_shift & bit_mask);
  assign rdata_aligned = (cur_word >> {offset, 3'b000}) & size_mask;

  // ---------------------------------------------------------------------------
  // Memory array update. Reset wins over any store presented in the same
  // cycle, so an in-flight store never partially lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.i_mem_write && legal) begin
      mem[word_idx] <= merged_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline read / misalignment registers. rdata_aligned is taken from the
  // array before this edge's write, giving read-before-write.
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0] read_data_q;
  logic               misaligned_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else if (access && !legal) begin
      read_data_q  <= '0;
      misaligned_q <= 1'b1;
    end else begin
      misaligned_q <= 1'b0;
      if (bus.i_mem_read) begin
        read_data_q <= rdata_aligned;
      end
    end
  end

  assign bus.o_read_data  = read_data_q;
  assign bus.o_misaligned = misaligned_q;

  // ---------------------------------------------------------------------------
  // Debug arbiter FSM
  // ---------------------------------------------------------------------------
  dbg_state_t         state_q;
  dbg_state_t         state_d;
  logic [NB_IDX-1:0]  debug_addr_q;
  logic [NB_IDX-1:0]  debug_rd_idx;
  logic [NB_DATA-1:0] debug_data_q;

  // On IDLE->RESPOND the index has not been latched yet, so use it directly.
  assign debug_rd_idx = (state_q == ST_IDLE) ? bus.i_debug_addr : debug_addr_q;

  // State register, latched index and response word.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      debug_addr_q <= '0;
      debug_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.i_debug_req) begin
        debug_addr_q <= bus.i_debug_addr;
      end
      // Entering RESPOND only happens in a cycle with no pipeline access, so
      // the array is not being written while it is sampled here.
      if (state_d == ST_RESPOND) begin
        debug_data_q <= mem[debug_rd_idx];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_debug_req) begin
          state_d = access ? ST_PENDING : ST_RESPOND;
        end
      end
      ST_PENDING: begin
        if (!access) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.o_debug_valid = (state_q == ST_RESPOND);
    bus.o_debug_state = state_q;
    bus.o_debug_data  = debug_data_q;
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int NB_DATA = 32;
  localparam int N_WORDS = 32;
  localparam int NB_ADDR = 7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // size encodings {word, halfword, byte}
  localparam logic [2:0] SZ_W  = 3'b100;
  localparam logic [2:0] SZ_H  = 3'b010;
  localparam logic [2:0] SZ_B  = 3'b001;
  localparam logic [2:0] SZ_WB = 3'b101;

  logic clk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;

  data_memory_if #(.NB_DATA(NB_DATA), .N_WORDS(N_WORDS), .NB_ADDR(NB_ADDR)) bus ();

  data_memory #(.NB_DATA(NB_DATA), .N_WORDS(N_WORDS), .NB_ADDR(NB_ADDR)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    bus.i_mem_read    = 1'b0;
    bus.i_mem_write   = 1'b0;
    bus.i_word_en     = 1'b0;
    bus.i_halfword_en = 1'b0;
    bus.i_byte_en     = 1'b0;
    bus.i_address     = '0;
    bus.i_write_data  = '0;
    bus.i_debug_req   = 1'b0;
    bus.i_debug_addr  = '0;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] size,
                          input logic [NB_ADDR-1:0] addr, input logic [NB_DATA-1:0] data);
    bus.i_mem_read    = rd;
    bus.i_mem_write   = wr;
    bus.i_word_en     = size[2];
    bus.i_halfword_en = size[1];
    bus.i_byte_en     = size[0];
    bus.i_address     = addr;
    bus.i_write_data  = data;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h0) $display("FAIL reset_read_data: got %h expected %h", bus.o_read_data, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b expected 0", bus.o_misaligned);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_valid !== 1'b0) $display("FAIL reset_debug_valid: got %b expected 0", bus.o_debug_valid);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_data !== 32'h0) $display("FAIL reset_debug_data: got %h expected %h", bus.o_debug_data, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.o_debug_state, ST_IDLE);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_word();
    drive_op(1'b0, 1'b1, SZ_W, 7'h08, 32'hAABBCCDD);
    tick();
    // write-only cycle leaves read data alone
    check_cnt++;
    if (bus.o_read_data !== 32'h0) $display("FAIL word_store_hold: got %h expected %h", bus.o_read_data, 32'h0);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABBCCDD) $display("FAIL word_load: got %h expected %h", bus.o_read_data, 32'hAABBCCDD);
    else pass_cnt++;
    set_idle();
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABBCCDD) $display("FAIL word_idle_hold: got %h expected %h", bus.o_read_data, 32'hAABBCCDD);
    else pass_cnt++;
  endtask

  task automatic test_byte();
    // upper bits of store data must be ignored for a byte store
    drive_op(1'b0, 1'b1, SZ_B, 7'h09, 32'hFFFFFF11);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABBCCDD) $display("FAIL byte_store_hold: got %h expected %h", bus.o_read_data, 32'hAABBCCDD);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABB11DD) $display("FAIL byte_store_word_load: got %h expected %h", bus.o_read_data, 32'hAABB11DD);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_B, 7'h0B, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h000000AA) $display("FAIL byte_load_0b: got %h expected %h", bus.o_read_data, 32'h000000AA);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_B, 7'h09, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h00000011) $display("FAIL byte_load_09: got %h expected %h", bus.o_read_data, 32'h00000011);
    else pass_cnt++;
  endtask

  task automatic test_halfword();
    drive_op(1'b1, 1'b0, SZ_H, 7'h0A, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h0000AABB) $display("FAIL half_load_0a: got %h expected %h", bus.o_read_data, 32'h0000AABB);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_misaligned !== 1'b0) $display("FAIL half_load_misaligned: got %b expected 0", bus.o_misaligned);
    else pass_cnt++;
    // misaligned halfword store
    drive_op(1'b0, 1'b1, SZ_H, 7'h0B, 32'h00005555);
    tick();
    check_cnt++;
    if (bus.o_misaligned !== 1'b1) $display("FAIL half_store_misaligned: got %b expected 1", bus.o_misaligned);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_read_data !== 32'h0) $display("FAIL half_store_mis_data: got %h expected %h", bus.o_read_data, 32'h0);
    else pass_cnt++;
    set_idle();
    tick();
    check_cnt++;
    if (bus.o_misaligned !== 1'b0) $display("FAIL misaligned_one_cycle: got %b expected 0", bus.o_misaligned);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABB11DD) $display("FAIL mis_store_no_write: got %h expected %h", bus.o_read_data, 32'hAABB11DD);
    else pass_cnt++;
    // legal halfword store into upper half of word 4 (address 0x10)
    drive_op(1'b0, 1'b1, SZ_H, 7'h12, 32'hFFFF9876);
    tick();
    drive_op(1'b1, 1'b0, SZ_W, 7'h10, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h98760000) $display("FAIL half_store_12: got %h expected %h", bus.o_read_data, 32'h98760000);
    else pass_cnt++;
    // misaligned word load
    drive_op(1'b1, 1'b0, SZ_W, 7'h09, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_misaligned !== 1'b1 || bus.o_read_data !== 32'h0)
      $display("FAIL word_load_misaligned: got mis=%b data=%h expected mis=1 data=0", bus.o_misaligned, bus.o_read_data);
    else pass_cnt++;
    // two size selects at once is illegal, even if aligned
    drive_op(1'b0, 1'b1, SZ_WB, 7'h08, 32'hFFFFFFFF);
    tick();
    check_cnt++;
    if (bus.o_misaligned !== 1'b1) $display("FAIL multi_size_illegal: got %b expected 1", bus.o_misaligned);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABB11DD) $display("FAIL multi_size_no_write: got %h expected %h", bus.o_read_data, 32'hAABB11DD);
    else pass_cnt++;
  endtask

  task automatic test_read_write();
    drive_op(1'b1, 1'b1, SZ_W, 7'h08, 32'h12345678);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'hAABB11DD) $display("FAIL rw_old_data: got %h expected %h", bus.o_read_data, 32'hAABB11DD);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h12345678) $display("FAIL rw_new_data: got %h expected %h", bus.o_read_data, 32'h12345678);
    else pass_cnt++;
    set_idle();
    tick();
  endtask

  task automatic test_debug_idle();
    set_idle();
    bus.i_debug_req  = 1'b1;
    bus.i_debug_addr = 5'd4;
    tick();
    bus.i_debug_req  = 1'b0;
    bus.i_debug_addr = 5'd0;
    check_cnt++;
    if (bus.o_debug_state !== ST_RESPOND || bus.o_debug_valid !== 1'b1)
      $display("FAIL debug_idle_respond: got state=%0d valid=%b expected state=2 valid=1", bus.o_debug_state, bus.o_debug_valid);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_data !== 32'h98760000) $display("FAIL debug_idle_data: got %h expected %h", bus.o_debug_data, 32'h98760000);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus.o_debug_valid !== 1'b0 || bus.o_debug_state !== ST_IDLE)
      $display("FAIL debug_idle_return: got state=%0d valid=%b expected state=0 valid=0", bus.o_debug_state, bus.o_debug_valid);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_data !== 32'h98760000) $display("FAIL debug_data_hold: got %h expected %h", bus.o_debug_data, 32'h98760000);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [NB_DATA-1:0] exp_q[$];
    logic [NB_DATA-1:0] exp_word;
    int pend_cycles;
    pend_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
      bus.i_debug_req  = 1'b1;
      // only the first request (index 2) is accepted; later ones are ignored
      bus.i_debug_addr = (c == 0) ? 5'd2 : 5'd0;
      exp_q.push_back(32'h12345678);
      tick();
      exp_word = exp_q.pop_front();
      check_cnt++;
      if (bus.o_read_data !== exp_word) $display("FAIL b2b_load%0d: got %h expected %h", c, bus.o_read_data, exp_word);
      else pass_cnt++;
      check_cnt++;
      if (bus.o_debug_valid !== 1'b0) $display("FAIL b2b_no_valid%0d: got %b expected 0", c, bus.o_debug_valid);
      else pass_cnt++;
      if (bus.o_debug_state === ST_PENDING) pend_cycles++;
    end
    set_idle();
    bus.i_debug_req  = 1'b1;
    bus.i_debug_addr = 5'd0;
    tick();
    bus.i_debug_req = 1'b0;
    check_cnt++;
    if (pend_cycles !== 3) $display("FAIL b2b_pending_cycles: got %0d expected 3", pend_cycles);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_state !== ST_RESPOND || bus.o_debug_valid !== 1'b1)
      $display("FAIL b2b_respond: got state=%0d valid=%b expected state=2 valid=1", bus.o_debug_state, bus.o_debug_valid);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_debug_data !== 32'h12345678) $display("FAIL b2b_debug_data: got %h expected %h", bus.o_debug_data, 32'h12345678);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus.o_debug_valid !== 1'b0 || bus.o_debug_state !== ST_IDLE)
      $display("FAIL b2b_return_idle: got state=%0d valid=%b expected state=0 valid=0", bus.o_debug_state, bus.o_debug_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_pending();
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    bus.i_debug_req  = 1'b1;
    bus.i_debug_addr = 5'd2;
    tick();
    check_cnt++;
    if (bus.o_debug_state !== ST_PENDING) $display("FAIL rp_pending: got %0d expected %0d", bus.o_debug_state, ST_PENDING);
    else pass_cnt++;
    // reset while a store to word 3 is also presented
    drive_op(1'b0, 1'b1, SZ_W, 7'h0C, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    check_cnt++;
    if (bus.o_debug_state !== ST_IDLE || bus.o_debug_valid !== 1'b0)
      $display("FAIL rp_idle: got state=%0d valid=%b expected state=0 valid=0", bus.o_debug_state, bus.o_debug_valid);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_cnt++;
      if (bus.o_debug_valid !== 1'b0) $display("FAIL rp_no_valid%0d: got %b expected 0", c, bus.o_debug_valid);
      else pass_cnt++;
    end
    drive_op(1'b1, 1'b0, SZ_W, 7'h08, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h0) $display("FAIL rp_mem_cleared: got %h expected %h", bus.o_read_data, 32'h0);
    else pass_cnt++;
    drive_op(1'b1, 1'b0, SZ_W, 7'h0C, 32'h0);
    tick();
    check_cnt++;
    if (bus.o_read_data !== 32'h0) $display("FAIL rp_store_discarded: got %h expected %h", bus.o_read_data, 32'h0);
    else pass_cnt++;
    set_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    rst       = 1'b1;
    set_idle();
    test_reset();
    test_word();
    test_byte();
    test_halfword();
    test_read_write();
    test_debug_idle();
    test_back_to_back();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
